// File: rtl/gmsk_burst_sequencer.sv
// Burst-level symbol sequencer for the GMSK transmit path: prime, arm, then head/payload/tail/guard per modulator strobe.
// Optional abort input and clear-underrun-on-fire are enabled by defining BURST_ABORT_EN.
module gmsk_burst_sequencer #(
    parameter int PRIME_SYMBOLS = 3,
    parameter int TAIL_SYMBOLS  = 3,
    parameter int GUARD_SYMBOLS = 8,
    parameter int LEN_BITS      = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                next_symbol_strobe,
    input  logic                fire_burst,
    input  logic [LEN_BITS-1:0] burst_length,
    input  logic                payload_bit,
    input  logic                payload_valid,
`ifdef BURST_ABORT_EN
    input  logic                burst_abort,
`endif
    output logic                payload_ready,
    output logic                current_symbol,
    output logic                is_armed,
    output logic                iq_valid,
    output logic                burst_active,
    output logic                burst_done,
    output logic                underrun
);

    typedef enum logic [2:0] {PRIME, ARMED, HEAD, PAYLOAD, TAIL, GUARD} state_t;

    localparam logic [LEN_BITS-1:0] PRIME_LAST = LEN_BITS'(PRIME_SYMBOLS - 1);
    localparam logic [LEN_BITS-1:0] TAIL_LAST  = LEN_BITS'(TAIL_SYMBOLS - 1);
    localparam logic [LEN_BITS-1:0] GUARD_LAST = LEN_BITS'(GUARD_SYMBOLS - 1);
    localparam logic [LEN_BITS-1:0] ONE        = LEN_BITS'(1);

    state_t              state;
    logic [LEN_BITS-1:0] counter;
    logic [LEN_BITS-1:0] latched_len;
    logic                abort_now;

`ifdef BURST_ABORT_EN
    logic abort_pending;

    // An abort seen between strobes is held until the next strobe consumes it.
    always_ff @(posedge clock) begin
        if (reset) begin
            abort_pending <= 1'b0;
        end else if (state == HEAD || state == PAYLOAD) begin
            if (next_symbol_strobe)
                abort_pending <= 1'b0;
            else if (burst_abort)
                abort_pending <= 1'b1;
        end else begin
            abort_pending <= 1'b0;
        end
    end

    assign abort_now = (state == HEAD || state == PAYLOAD) && (abort_pending || burst_abort);
`else
    assign abort_now = 1'b0;
`endif

    // The pop must coincide with the strobe that samples payload_bit.
    assign payload_ready = !reset && next_symbol_strobe && (state == PAYLOAD) && !abort_now;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= PRIME;
            counter        <= '0;
            latched_len    <= '0;
            current_symbol <= 1'b1;
            is_armed       <= 1'b0;
            iq_valid       <= 1'b0;
            burst_active   <= 1'b0;
            burst_done     <= 1'b0;
            underrun       <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            case (state)
                PRIME: begin
                    if (next_symbol_strobe) begin
                        current_symbol <= 1'b1;
                        if (counter == PRIME_LAST) begin
                            counter  <= '0;
                            state    <= ARMED;
                            is_armed <= 1'b1;
                        end else begin
                            counter <= counter + ONE;
                        end
                    end
                end
                ARMED: begin
                    if (next_symbol_strobe)
                        current_symbol <= 1'b1;
                    if (fire_burst) begin
                        latched_len  <= burst_length;
                        is_armed     <= 1'b0;
                        burst_active <= 1'b1;
                        counter      <= '0;
                        state        <= HEAD;
`ifdef BURST_ABORT_EN
                        underrun     <= 1'b0;
`endif
                    end
                end
                HEAD, PAYLOAD: begin
                    if (next_symbol_strobe) begin
                        // An aborting strobe already emits the first tail zero.
                        if (abort_now) begin
                            current_symbol <= 1'b0;
                            iq_valid       <= 1'b1;
                            if (TAIL_LAST == '0) begin
                                state   <= GUARD;
                                counter <= '0;
                            end else begin
                                state   <= TAIL;
                                counter <= ONE;
                            end
                        end else if (state == HEAD) begin
                            current_symbol <= 1'b0;
                            iq_valid       <= 1'b1;
                            if (counter == TAIL_LAST) begin
                                counter <= '0;
                                state   <= (latched_len == '0) ? TAIL : PAYLOAD;
                            end else begin
                                counter <= counter + ONE;
                            end
                        end else begin
                            if (payload_valid) begin
                                current_symbol <= payload_bit;
                            end else begin
                                current_symbol <= 1'b1;
                                underrun       <= 1'b1;
                            end
                            if (counter == latched_len - ONE) begin
                                counter <= '0;
                                state   <= TAIL;
                            end else begin
                                counter <= counter + ONE;
                            end
                        end
                    end
                end
                TAIL: begin
                    if (next_symbol_strobe) begin
                        current_symbol <= 1'b0;
                        if (counter == TAIL_LAST) begin
                            counter <= '0;
                            state   <= GUARD;
                        end else begin
                            counter <= counter + ONE;
                        end
                    end
                end
                GUARD: begin
                    if (next_symbol_strobe) begin
                        current_symbol <= 1'b1;
                        iq_valid       <= 1'b0;
                        if (counter == GUARD_LAST) begin
                            counter      <= '0;
                            state        <= ARMED;
                            burst_done   <= 1'b1;
                            burst_active <= 1'b0;
                            is_armed     <= 1'b1;
                        end else begin
                            counter <= counter + ONE;
                        end
                    end
                end
                default: state <= PRIME;
            endcase
        end
    end

endmodule

// File: tb/tb_gmsk_burst_sequencer.sv
// Directed bench for gmsk_burst_sequencer; payload comes from a bench-side bit list popped on payload_ready.
// Abort scenario is exercised only when BURST_ABORT_EN is defined.
module tb_gmsk_burst_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       next_symbol_strobe = 1'b0;
    logic       fire_burst = 1'b0;
    logic [7:0] burst_length = 8'h00;
    logic       payload_bit;
    logic       payload_valid = 1'b1;
    logic       burst_abort = 1'b0;
    logic       payload_ready, current_symbol, is_armed, iq_valid, burst_active, burst_done, underrun;

    // Payload source: bit k is the k-th bit handed out.
    logic [63:0] src_bits = 64'h1CD;
    int          src_idx = 0;
    int          ready_cnt = 0;
    int          done_cnt = 0;
    int          compared = 0;
    int          mismatched = 0;

    assign payload_bit = src_bits[src_idx[5:0]];

    always #5 clock = ~clock;

    gmsk_burst_sequencer dut (
        .clock              (clock),
        .reset              (reset),
        .next_symbol_strobe (next_symbol_strobe),
        .fire_burst         (fire_burst),
        .burst_length       (burst_length),
        .payload_bit        (payload_bit),
        .payload_valid      (payload_valid),
`ifdef BURST_ABORT_EN
        .burst_abort        (burst_abort),
`endif
        .payload_ready      (payload_ready),
        .current_symbol     (current_symbol),
        .is_armed           (is_armed),
        .iq_valid           (iq_valid),
        .burst_active       (burst_active),
        .burst_done         (burst_done),
        .underrun           (underrun)
    );

    always @(posedge clock) begin
        if (payload_ready && payload_valid) src_idx <= src_idx + 1;
        if (payload_ready) ready_cnt <= ready_cnt + 1;
        if (burst_done) done_cnt <= done_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One strobe; ready is sampled before the edge, registered outputs after it.
    task automatic applyStimulus(input logic valid_in, output logic rdy, output logic sym,
                                 output logic iq, output logic done, output logic armed);
        @(negedge clock);
        payload_valid      = valid_in;
        next_symbol_strobe = 1'b1;
        #1 rdy = payload_ready;
        @(negedge clock);
        sym   = current_symbol;
        iq    = iq_valid;
        done  = burst_done;
        armed = is_armed;
        next_symbol_strobe = 1'b0;
        payload_valid      = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic runSymbols(input string tag, input int n, input logic [31:0] exp_sym,
                              input logic [31:0] exp_iq, input logic [31:0] exp_rdy,
                              input logic [31:0] invalid, input logic final_done);
        logic r, s, q, d, a;
        for (int i = 0; i < n; i++) begin
            applyStimulus(!invalid[i], r, s, q, d, a);
            checkOutput($sformatf("%s_sym%0d", tag, i), s, exp_sym[i]);
            checkOutput($sformatf("%s_iq%0d", tag, i), q, exp_iq[i]);
            checkOutput($sformatf("%s_rdy%0d", tag, i), r, exp_rdy[i]);
            checkOutput($sformatf("%s_done%0d", tag, i), d, final_done && (i == n - 1));
        end
    endtask

    task automatic fireBurst(input logic [7:0] len, input logic with_strobe);
        @(negedge clock);
        fire_burst         = 1'b1;
        burst_length       = len;
        next_symbol_strobe = with_strobe;
        @(negedge clock);
        fire_burst         = 1'b0;
        next_symbol_strobe = 1'b0;
        burst_length       = 8'hAA;
    endtask

    task automatic primeAndArm(input string tag);
        logic r, s, q, d, a;
        applyStimulus(1'b1, r, s, q, d, a);
        checkOutput({tag, "_sym1"}, s, 1'b1);
        checkOutput({tag, "_armed1"}, a, 1'b0);
        applyStimulus(1'b1, r, s, q, d, a);
        checkOutput({tag, "_armed2"}, a, 1'b0);
        checkOutput({tag, "_iq2"}, q, 1'b0);
        applyStimulus(1'b1, r, s, q, d, a);
        checkOutput({tag, "_armed3"}, a, 1'b1);
        checkOutput({tag, "_sym3"}, s, 1'b1);
        checkOutput({tag, "_rdy3"}, r, 1'b0);
    endtask

    initial begin
        int r0, p0, d0;

        repeat (2) @(negedge clock);
        checkOutput("rst_sym", current_symbol, 1'b1);
        checkOutput("rst_armed", is_armed, 1'b0);
        checkOutput("rst_iq", iq_valid, 1'b0);
        checkOutput("rst_active", burst_active, 1'b0);
        checkOutput("rst_done", burst_done, 1'b0);
        checkOutput("rst_ready", payload_ready, 1'b0);
        checkOutput("rst_underrun", underrun, 1'b0);
        reset = 1'b0;

        primeAndArm("prime");

        // Burst 1: length 4, payload 1,0,1,1.
        r0 = ready_cnt; p0 = src_idx; d0 = done_cnt;
        fireBurst(8'd4, 1'b0);
        checkOutput("b1_armed", is_armed, 1'b0);
        checkOutput("b1_active", burst_active, 1'b1);
        checkOutput("b1_iq_pre", iq_valid, 1'b0);
        runSymbols("b1", 18, 32'b11111111_0001101000, 32'b00000000_1111111111,
                   32'b00000000_0001111000, 32'h0, 1'b1);
        checkOutput("b1_ready_cnt", ready_cnt - r0, 4);
        checkOutput("b1_pops", src_idx - p0, 4);
        checkOutput("b1_done_cnt", done_cnt - d0, 1);
        checkOutput("b1_active_end", burst_active, 1'b0);
        checkOutput("b1_armed_end", is_armed, 1'b1);
        checkOutput("b1_done_low", burst_done, 1'b0);

        // Burst 2: zero-length payload.
        r0 = ready_cnt; d0 = done_cnt;
        fireBurst(8'd0, 1'b0);
        runSymbols("b2", 14, 32'b11111111_000000, 32'b00000000_111111, 32'h0, 32'h0, 1'b1);
        checkOutput("b2_ready_cnt", ready_cnt - r0, 0);
        checkOutput("b2_done_cnt", done_cnt - d0, 1);

        // Burst 3: length 3, payload_valid low on the second payload strobe.
        r0 = ready_cnt; p0 = src_idx;
        fireBurst(8'd3, 1'b0);
        runSymbols("b3", 17, 32'b11111111_000010000, 32'b00000000_111111111,
                   32'b00000000_000111000, 32'b00000000_000010000, 1'b1);
        checkOutput("b3_ready_cnt", ready_cnt - r0, 3);
        checkOutput("b3_pops", src_idx - p0, 2);
        checkOutput("b3_underrun", underrun, 1'b1);

        // Burst 4: fire on a strobe cycle, then a stray fire mid-payload, then reset.
        p0 = src_idx;
        fireBurst(8'd4, 1'b1);
        checkOutput("b4_sym_fire", current_symbol, 1'b1);
        checkOutput("b4_iq_fire", iq_valid, 1'b0);
        checkOutput("b4_armed", is_armed, 1'b0);
        checkOutput("b4_active", burst_active, 1'b1);
`ifdef BURST_ABORT_EN
        checkOutput("b4_underrun", underrun, 1'b0);
`else
        checkOutput("b4_underrun", underrun, 1'b1);
`endif
        runSymbols("b4a", 4, 32'b1000, 32'b1111, 32'b1000, 32'h0, 1'b0);
        fireBurst(8'd1, 1'b0);
        checkOutput("b4_stray_armed", is_armed, 1'b0);
        checkOutput("b4_stray_active", burst_active, 1'b1);
        runSymbols("b4b", 1, 32'b1, 32'b1, 32'b1, 32'h0, 1'b0);
        checkOutput("b4_pops", src_idx - p0, 2);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("mid_rst_iq", iq_valid, 1'b0);
        checkOutput("mid_rst_sym", current_symbol, 1'b1);
        checkOutput("mid_rst_active", burst_active, 1'b0);
        checkOutput("mid_rst_armed", is_armed, 1'b0);
        checkOutput("mid_rst_underrun", underrun, 1'b0);
        reset = 1'b0;
        primeAndArm("reprime");

`ifdef BURST_ABORT_EN
        // Abort after two payload symbols of a 10-symbol burst.
        p0 = src_idx; d0 = done_cnt;
        fireBurst(8'd10, 1'b0);
        runSymbols("ab1", 5, 32'b01000, 32'b11111, 32'b11000, 32'h0, 1'b0);
        @(negedge clock);
        burst_abort = 1'b1;
        @(negedge clock);
        burst_abort = 1'b0;
        runSymbols("ab2", 11, 32'b11111111000, 32'b00000000111, 32'h0, 32'h0, 1'b1);
        checkOutput("ab_pops", src_idx - p0, 2);
        checkOutput("ab_done_cnt", done_cnt - d0, 1);
        checkOutput("ab_armed", is_armed, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
